// File: rtl/switch_input_fifo.sv
// rtl/switch_input_fifo.sv - edge-triggered capture FIFO for debounced switch words with a status/data read port
module switch_input_fifo #(
  parameter int DATA_W = 31,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        y1,
  input  logic [29:0] y2,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        not_empty,
  output logic        overflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    count;
  logic              start_prev;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              empty;
  logic              full;
  logic              data_rd;
  logic              status_rd;
  logic [DATA_W-1:0] word;
  logic [31:0]       status;

  assign word      = DATA_W'({y1, y2});
  assign push      = start & ~start_prev;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign data_rd   = rd_en & rd_sel;
  assign status_rd = rd_en & ~rd_sel;
  assign pop       = data_rd & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign not_empty = ~empty;
  assign status    = {overflow, {(28-PTR_W){1'b0}}, count, full, empty};

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[PTR_W-1:0]] <= word;
    end
  end

  // Pointers, edge detector, sticky overflow and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      start_prev <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      start_prev <= start;
      rd_valid   <= rd_en;
      if (push_ok) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      if (data_rd) begin
        rd_data <= empty ? 32'h0 : 32'(mem[rd_ptr[PTR_W-1:0]]);
      end else if (status_rd) begin
        rd_data <= status;
      end
      // A fresh drop outranks the read-to-clear of a status access.
      if (drop) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_input_fifo.sv
// tb/tb_switch_input_fifo.sv - vector-table bench for switch_input_fifo
module tb_switch_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        y1;
  logic [29:0] y2;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        not_empty;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        start;
    logic [30:0] y;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_ne;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  switch_input_fifo dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .y1(y1),
    .y2(y2),
    .rd_en(rd_en),
    .rd_sel(rd_sel),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .not_empty(not_empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input int s, input int y, input int re, input int rs,
                              input int d, input int v, input int ne, input int ov);
    vec_t t;
    t.start     = s[0];
    t.y         = 31'(y);
    t.rd_en     = re[0];
    t.rd_sel    = rs[0];
    t.exp_data  = 32'(d);
    t.exp_valid = v[0];
    t.exp_ne    = ne[0];
    t.exp_ovf   = ov[0];
    vecs.push_back(t);
  endfunction

  task automatic step(input int s, input int y, input int re, input int rs);
    logic [30:0] w;
    w      = 31'(y);
    start  = s[0];
    y1     = w[30];
    y2     = w[29:0];
    rd_en  = re[0];
    rd_sel = rs[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    // press with start held through reset, single read of each register
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h4000_0005, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 32'h4000_0005, 1, 0, 0);
    add(1, 0, 1, 0, 32'h0000_0001, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0000_0001, 0, 0, 0);
    // long held level gives one push
    add(0, 32'h123, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 32'h123, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 32'h0000_0004, 1, 1, 0);
    add(1, 0, 1, 1, 32'h0000_0123, 1, 0, 0);
    // five presses into four entries
    for (int k = 1; k <= 5; k++) begin
      add(0, k, 0, 0, 32'h123, 0, int'(k > 1), 0);
      add(1, k, 0, 0, 32'h123, 0, 1, int'(k == 5));
    end
    add(0, 0, 1, 0, 32'h8000_0012, 1, 1, 0);
    add(0, 0, 1, 0, 32'h0000_0012, 1, 1, 0);
    add(0, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 2, 1, 1, 0);
    add(0, 0, 1, 1, 3, 1, 1, 0);
    add(0, 0, 1, 1, 4, 1, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 32'h0000_0001, 1, 0, 0);
    // full FIFO: push and pop in one cycle
    for (int k = 11; k <= 14; k++) begin
      add(0, k, 0, 0, 1, 0, int'(k > 11), 0);
      add(1, k, 0, 0, 1, 0, 1, 0);
    end
    add(0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 15, 1, 1, 11, 1, 1, 0);
    add(0, 0, 1, 0, 32'h0000_0012, 1, 1, 0);
    add(0, 0, 1, 1, 12, 1, 1, 0);
    add(0, 0, 1, 1, 13, 1, 1, 0);
    add(0, 0, 1, 1, 14, 1, 1, 0);
    add(0, 0, 1, 1, 15, 1, 0, 0);
    add(0, 0, 1, 0, 32'h0000_0001, 1, 0, 0);
    // empty FIFO: push and data read in one cycle
    add(1, 21, 1, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 32'h0000_0004, 1, 1, 0);
    add(1, 0, 1, 1, 21, 1, 0, 0);
    add(0, 0, 0, 0, 21, 0, 0, 0);

    rst = 1'b1;
    start = 1'b1; y1 = 1'b0; y2 = '0; rd_en = 1'b0; rd_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_data", rd_data, 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset not_empty", 32'(not_empty), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(int'(vecs[i].start), int'(vecs[i].y), int'(vecs[i].rd_en), int'(vecs[i].rd_sel));
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
      check($sformatf("vec%0d valid/ne/ovf", i), {29'h0, rd_valid, not_empty, overflow},
            {29'h0, vecs[i].exp_valid, vecs[i].exp_ne, vecs[i].exp_ovf});
    end

    // reset while three words are queued and a read is in flight
    for (int k = 31; k <= 33; k++) begin
      step(1, k, 0, 0);
      step(0, 0, 0, 0);
    end
    check("midrst pre not_empty", 32'(not_empty), 32'h1);
    start = 1'b0; rd_en = 1'b1; rd_sel = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst rd_valid", 32'(rd_valid), 32'h0);
    check("midrst rd_data", rd_data, 32'h0);
    check("midrst not_empty", 32'(not_empty), 32'h0);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 1, 0);
    check("midrst status", rd_data, 32'h0000_0001);
    check("midrst status valid", 32'(rd_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_input_fifo.md
Name: switch_input_fifo

Overview:
- Downstream consumer of the debounced switch-latch stage. That stage presents a latched 31-bit word {y1,y2} and a start level that rises after each debounced button press.
- This block edge-detects start and pushes the latched word into a small FIFO.
- Exposes the FIFO to the RV32 core as a two-register memory-mapped read port (status, data), so presses are never lost while the program is busy.

Parameters:
- DATA_W, 31, width of one queued word ({y1,y2}).
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), index width; count field is PTR_W+1 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  level from upstream latch stage; each rising edge = one new word.
- y1  in  1  latched word bit 30.
- y2  in  30  latched word bits 29:0.
- rd_en  in  1  core read strobe, one cycle per access.
- rd_sel  in  1  0 = status register, 1 = data register.
- rd_data  out  32  read result, registered.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- not_empty  out  1  FIFO holds at least one word (interrupt/poll line).
- overflow  out  1  sticky: a press was dropped.

Behaviour:
- Reset: reset rst, asynchronous, active-high; clock clk. All pointers and count = 0; rd_data = 0; rd_valid = 0; overflow = 0; storage contents don't-care.
- start_prev resets to 1, so a start held high through reset release does not push.
- Edge detect: push = start & ~start_prev; start_prev <= start every cycle. A start level held N cycles gives exactly one push.
- Push:
  - Sample {y1,y2} in the same cycle push is asserted; upstream guarantees y is stable before start rises.
  - Write at wr_ptr; wr_ptr++ (wraps modulo DEPTH).
- Pointers: wr_ptr and rd_ptr carry one extra wrap bit (PTR_W+1).
  - empty = pointers equal.
  - full = index bits equal, wrap bits differ.
  - count = wr_ptr - rd_ptr.
- Data read (rd_en & rd_sel):
  - Not empty: next cycle rd_data = {1'b0, mem[rd_ptr]}; rd_ptr++.
  - Empty: rd_data = 0; no pointer change.
  - rd_valid = 1 on that next cycle in both cases.
- Status read (rd_en & ~rd_sel): next cycle rd_data = {overflow, 31-PTR_W-3 zeros, count, full, empty}.
  - bit0 = empty; bit1 = full; bits[PTR_W+2:2] = count; bit31 = overflow.
  - Reports the state before any same-cycle push.
  - overflow clears after the read (read-to-clear).
- Overflow: push while full and no same-cycle pop → word dropped, overflow <= 1. A new drop in the same cycle as a status read wins: overflow stays 1.
- Simultaneous push + data read:
  - Full: pop and push both occur; count stays DEPTH; no overflow.
  - Empty: read returns 0 (no pop); push accepted; count = 1 next cycle.
  - Otherwise: count unchanged; returned word is the old head.
- rd_data holds its last value when rd_en = 0; rd_valid = 0 when rd_en = 0.
- not_empty = ~empty, driven from registered pointers (no combinational path from inputs).
- Latency: press-to-not_empty is 1 cycle after start rises; read-to-data is 1 cycle.
- Reset mid-operation: immediately empties FIFO, clears overflow and rd_data. In-flight read returns nothing (rd_valid stays 0).

Test Plan:
- Reset with start=1, then release → no push, not_empty=0. Drop start, then raise it with {y1,y2}=31'h4000_0005 → not_empty=1 after 1 cycle; data read returns 32'h4000_0005, rd_valid pulse; status read then = 32'h0000_0001.
- Hold start high 20 cycles → exactly one push; status count=1.
- Five edges with words 1..5 at DEPTH=4:
  - Status = 32'h8000_0012 (overflow, count 4, full).
  - A second status read = 32'h0000_0012.
  - Data reads return 1,2,3,4, then 0 with status empty.
- Full FIFO, push edge and data read in the same cycle → read returns oldest word; count stays 4; overflow=0; new word read last.
- Empty FIFO, push edge and data read in the same cycle → read returns 0; next status = 32'h0000_0004 (count 1).
- Assert rst mid-stream with 3 words queued and a read issued → rd_valid stays 0; rd_data=0; status afterwards = 32'h0000_0001.
